i2c_wr_ctrl: RTL

// - I2C write-only bus master for the audio codec control port.
// - Sits between the codec configuration sequencer and the SCL/SDA pins.
// - While i_enb is high, serialises one 16-bit register write per frame:
//   {7-bit reg addr, 9-bit data}.
// - Reports o_next after each frame and o_done when the bus is idle.

---
 rtl/i2c_wr_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/i2c_wr_ctrl.sv
// Write-only I2C master for the audio codec control port: one {7-bit reg, 9-bit data}
// word per frame, framed as device byte + two payload bytes, each ACK-checked.
`timescale 1ns/1ps
module i2c_wr_ctrl #(
  parameter int         CLK_DIV  = 125,
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enb,
  input  logic [6:0] i_addr,
  input  logic [8:0] i_data,
  output logic       o_next,
  output logic       o_done,
  output logic       o_scl,
  output logic       o_sda_oe,
  input  logic       i_sda,
  output logic       o_ack_err
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, SHIFT, ACK, STOP, BUF} state_t;

  state_t      state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [1:0]  q, q_nxt;
  logic [2:0]  bit_idx, bit_nxt;
  logic [1:0]  byte_idx, byte_nxt;
  logic [23:0] shreg, shreg_nxt;
  logic        nack, nack_nxt;
  logic        err_nxt, scl_nxt, oe_nxt, next_nxt;
  logic        tick, slot_end;

  assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign slot_end = tick && (q == 2'd3);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    div_nxt   = tick ? '0 : div_cnt + 1'b1;
    q_nxt     = tick ? q + 2'd1 : q;
    bit_nxt   = bit_idx;
    byte_nxt  = byte_idx;
    shreg_nxt = shreg;
    nack_nxt  = nack;
    err_nxt   = o_ack_err;
    next_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_enb) begin
          shreg_nxt = {DEV_ADDR, 1'b0, i_addr, i_data};
          state_nxt = START;
        end
      end
      START: begin
        if (slot_end) begin
          state_nxt = SHIFT;
          bit_nxt   = 3'd0;
          byte_nxt  = 2'd0;
        end
      end
      SHIFT: begin
        if (slot_end) begin
          shreg_nxt = {shreg[22:0], 1'b0};
          if (bit_idx == 3'd7) state_nxt = ACK;
          else                 bit_nxt   = bit_idx + 3'd1;
        end
      end
      ACK: begin
        // Slave's answer is taken at the end of Q2, just before SCL has been high a full quarter.
        if (tick && q == 2'd2) nack_nxt = i_sda;
        if (slot_end) begin
          if (nack) begin
            err_nxt   = 1'b1;
            state_nxt = STOP;
          end else if (byte_idx == 2'd2) begin
            state_nxt = STOP;
          end else begin
            state_nxt = SHIFT;
            byte_nxt  = byte_idx + 2'd1;
            bit_nxt   = 3'd0;
          end
        end
      end
      STOP: begin
        if (slot_end) begin
          state_nxt = BUF;
          next_nxt  = 1'b1;
        end
      end
      BUF: begin
        if (slot_end) begin
          if (i_enb) begin
            shreg_nxt = {DEV_ADDR, 1'b0, i_addr, i_data};
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state || state == IDLE) begin
      div_nxt = '0;
      q_nxt   = '0;
    end

    // Pin levels are decoded from the next state so they leave a flop glitch-free.
    scl_nxt = 1'b1;
    oe_nxt  = 1'b0;
    unique case (state_nxt)
      START: begin
        scl_nxt = (q_nxt != 2'd3);
        oe_nxt  = q_nxt[1];
      end
      SHIFT: begin
        scl_nxt = q_nxt[1];
        oe_nxt  = ~shreg_nxt[23];
      end
      ACK:  scl_nxt = q_nxt[1];
      STOP: begin
        scl_nxt = q_nxt[1];
        oe_nxt  = (q_nxt != 2'd3);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      q         <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      nack      <= 1'b0;
      o_scl     <= 1'b1;
      o_sda_oe  <= 1'b0;
      o_next    <= 1'b0;
      o_done    <= 1'b1;
      o_ack_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      q         <= q_nxt;
      bit_idx   <= bit_nxt;
      byte_idx  <= byte_nxt;
      nack      <= nack_nxt;
      o_scl     <= scl_nxt;
      o_sda_oe  <= oe_nxt;
      o_next    <= next_nxt;
      o_done    <= (state_nxt == IDLE);
      o_ack_err <= err_nxt;
    end
  end

  // NOTE: the shift register is pure datapath, always loaded before use, so it needs no reset.
  always_ff @(posedge i_clk) begin
    shreg <= shreg_nxt;
  end

endmodule
